adc_sample_uart_tx: RTL and testbench

//  Consumer end of the TDC ADC result path: accepts (FINE_BITS+1)-bit conversion results from
//  the dual-TDC core (one per ramp period) and streams them off-chip as 8N1 UART frames.

---
 rtl/adc_tx_pkg.sv | 31 +++
 rtl/adc_sample_uart_tx_if.sv | 11 +
 rtl/adc_sample_fifo.sv | 46 ++++
 rtl/adc_sample_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_adc_sample_uart_tx.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_tx_pkg.sv
// Shared types and frame layout for the ADC sample UART streamer.
// ADC_TX_SEQNUM_EN selects 3-byte frames carrying a 7-bit sequence number.
package adc_tx_pkg;

   typedef logic [2:0] tx_state_t;

   localparam tx_state_t ST_IDLE  = 3'd0;
   localparam tx_state_t ST_LOAD  = 3'd1;
   localparam tx_state_t ST_START = 3'd2;
   localparam tx_state_t ST_DATA  = 3'd3;
   localparam tx_state_t ST_STOP  = 3'd4;

   localparam logic SYNC_MARK = 1'b1;

`ifdef ADC_TX_SEQNUM_EN
   localparam int FRAME_BYTES = 3;
`else
   localparam int FRAME_BYTES = 2;
`endif
   localparam int FRAME_W = 8 * FRAME_BYTES;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   // Returns {byte1, byte0}; only byte0 carries the sync marker in its MSB.
   function automatic logic [15:0] frame_pair(input logic [9:0] s);
      return {1'b0, 3'b000, s[3:0], SYNC_MARK, 1'b0, s[9:4]};
   endfunction

endpackage

// File: rtl/adc_sample_uart_tx_if.sv
// Sample input bundle from the TDC ADC core into the UART streamer.
interface adc_sample_uart_tx_if #(parameter int W = 10);
   // sample_valid is a one-cycle qualifier with no ready: the producer never
   // stalls, so a sample offered to a full FIFO is dropped and counted.
   logic [W-1:0] sample;
   logic         sample_valid;
   logic         overflow_clr;

   modport master (output sample, sample_valid, overflow_clr);
   modport slave  (input  sample, sample_valid, overflow_clr);
endinterface

// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO with occupancy count; read data is valid while non-empty.
module adc_sample_fifo #(
   parameter  int W     = 10,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);

endmodule

// File: rtl/adc_sample_uart_tx.sv
// Buffers ADC samples and streams them as sync-marked 8N1 UART frames.
// ADC_TX_SEQNUM_EN appends a 7-bit frame sequence byte.
import adc_tx_pkg::*;

module adc_sample_uart_tx #(
   parameter  int FINE_BITS  = 9,
   parameter  int CLK_HZ     = 48000000,
   parameter  int BAUD       = 3000000,
   parameter  int FIFO_DEPTH = 16,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clock,
   input  logic                 reset,
   adc_sample_uart_tx_if.slave  in_if,
   output logic                 tx,
   output logic                 busy,
   output logic                 overflow,
   output logic [7:0]           drop_count,
   output logic [LW-1:0]        fifo_level,
   output tx_state_t            fsm_state
);

   localparam int SW  = FINE_BITS + 1;
   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int CW  = $clog2(CPB);
   localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

   tx_state_t           state;
   logic [SW-1:0]       fifo_dout;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic                drop;
   logic [CW-1:0]       baud_cnt;
   logic                baud_done;
   logic [2:0]          bit_idx;
   logic [1:0]          byte_idx;
   logic [FRAME_W-1:0]  frame;
   logic [FRAME_W-1:0]  next_frame;
   logic [7:0]          cur_byte;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign pop  = (state == ST_LOAD);
   assign push = in_if.sample_valid && (!fifo_full || pop);
   assign drop = in_if.sample_valid && fifo_full && !pop;

   adc_sample_fifo #(.W(SW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (in_if.sample[FINE_BITS:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

`ifdef ADC_TX_SEQNUM_EN
   logic [6:0] seq;

   always_ff @(posedge clock) begin
      if (reset)             seq <= '0;
      else if (state == ST_LOAD) seq <= seq + 1'b1;
   end

   assign next_frame = {1'b0, seq, frame_pair(fifo_dout[9:0])};
`else
   assign next_frame = frame_pair(fifo_dout[9:0]);
`endif

   // A clear coinciding with a drop leaves exactly that one drop recorded.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (in_if.overflow_clr) begin
         overflow   <= drop;
         drop_count <= {7'd0, drop};
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      end
   end

   assign baud_done = (baud_cnt == '0);
   assign cur_byte  = frame[8*byte_idx +: 8];

   // tx is registered from the current state, so the line lags the FSM by one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         frame    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               if (!fifo_empty) state <= ST_LOAD;
            end
            ST_LOAD: begin
               tx       <= 1'b1;
               busy     <= 1'b1;
               frame    <= next_frame;
               byte_idx <= '0;
               bit_idx  <= '0;
               baud_cnt <= CW'(CPB - 1);
               state    <= ST_START;
            end
            ST_START: begin
               tx <= 1'b0;
               if (baud_done) begin
                  baud_cnt <= CW'(CPB - 1);
                  bit_idx  <= '0;
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            ST_DATA: begin
               tx <= cur_byte[bit_idx];
               if (baud_done) begin
                  baud_cnt <= CW'(CPB - 1);
                  if (bit_idx == 3'd7) state <= ST_STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            ST_STOP: begin
               tx <= 1'b1;
               if (baud_done) begin
                  baud_cnt <= CW'(CPB - 1);
                  if (byte_idx == LAST_BYTE) begin
                     state <= ST_IDLE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                     state    <= ST_START;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_adc_sample_uart_tx.sv
// Self-checking bench: UART decoder monitor plus frame-level scoreboard model.
module tb_adc_sample_uart_tx;

   localparam int CPB   = 48000000 / 3000000;
   localparam int DEPTH = 16;
`ifdef ADC_TX_SEQNUM_EN
   localparam int NB = 3;
`else
   localparam int NB = 2;
`endif

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   adc_sample_uart_tx_if #(.W(10)) in_if ();
   logic       tx;
   logic       busy;
   logic       overflow;
   logic [7:0] drop_count;
   logic [4:0] fifo_level;
   logic [2:0] fsm_state;

   adc_sample_uart_tx dut (
      .clock      (clock),
      .reset      (reset),
      .in_if      (in_if),
      .tx         (tx),
      .busy       (busy),
      .overflow   (overflow),
      .drop_count (drop_count),
      .fifo_level (fifo_level),
      .fsm_state  (fsm_state)
   );

   int checks = 0;
   int errors = 0;

   // scoreboard
   logic [7:0] exp_q[$];
   int         exp_seq = 0;

   // monitor outputs
   logic [7:0] rx_q[$];
   int         start_q[$];
   int         frame_err = 0;
   bit         mon_active = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference framing: sync marker + upper six bits, then low nibble, then optional sequence.
   task automatic add_expected(input logic [9:0] s);
      int v;
      v = int'(s);
      exp_q.push_back(8'(128 + v / 16));
      exp_q.push_back(8'(v % 16));
      if (NB == 3) exp_q.push_back(8'(exp_seq % 128));
      exp_seq++;
   endtask

   // UART receiver: samples mid-bit on the falling clock edge
   initial begin
      int cnt;
      int cyc;
      logic [7:0] b;
      cnt = 0;
      cyc = 0;
      b   = '0;
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            mon_active = 1'b0;
         end else if (!mon_active) begin
            if (tx === 1'b0) begin
               mon_active = 1'b1;
               cnt = 0;
               start_q.push_back(cyc);
            end
         end else begin
            cnt++;
            if (cnt == CPB / 2 && tx !== 1'b0) frame_err++;
            for (int k = 0; k < 8; k++)
               if (cnt == (k + 1) * CPB + CPB / 2) b[k] = tx;
            if (cnt == 9 * CPB + CPB / 2) begin
               if (tx !== 1'b1) frame_err++;
               rx_q.push_back(b);
               mon_active = 1'b0;
            end
         end
      end
   end

   // driver tasks
   task automatic drive_cycle(input bit v, input logic [9:0] s, input bit clr);
      in_if.sample_valid = v;
      in_if.sample       = s;
      in_if.overflow_clr = clr;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 10'd0, 1'b0);
   endtask

   task automatic burst(input int n);
      int acc;
      logic [9:0] s;
      acc = (n <= DEPTH + 1) ? n : DEPTH + 1;
      for (int i = 0; i < n; i++) begin
         s = 10'($urandom_range(0, 1023));
         drive_cycle(1'b1, s, 1'b0);
         if (i < acc) add_expected(s);
      end
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (!(fifo_level == 5'd0 && busy == 1'b0 && !mon_active) && n < bound) begin
         drive_cycle(1'b0, 10'd0, 1'b0);
         n++;
      end
      checks++;
      assert (n < bound) else begin
         errors++;
         $error("FAIL drain_timeout observed=%0d expected_below=%0d", n, bound);
      end
   endtask

   task automatic check_stream(input string tag, input bit back_to_back);
      int n;
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      if (back_to_back)
         for (int i = 1; i < start_q.size(); i++)
            check($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1],
                  (i % NB == 0) ? 10 * CPB + 2 : 10 * CPB);
      rx_q.delete();
      exp_q.delete();
      start_q.delete();
   endtask

   initial begin
      in_if.sample_valid = 1'b0;
      in_if.sample       = '0;
      in_if.overflow_clr = 1'b0;

      // reset state
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_fifo_level", fifo_level, 0);
      idle(3);
      rx_q.delete();
      start_q.delete();

      // single sample: latency, exact bit widths, busy release
      drive_cycle(1'b1, 10'h2A5, 1'b0);
      add_expected(10'h2A5);
      idle(1);
      check("lat_n1_tx", tx, 1);
      idle(1);
      check("lat_n2_tx", tx, 1);
      check("lat_n2_busy", busy, 1);
      idle(1);
      for (int j = 0; j < 10 * NB; j++) begin
         int bad;
         int pos;
         logic ebit;
         logic [7:0] eb;
         bad = 0;
         eb  = exp_q[j / 10];
         pos = j % 10;
         ebit = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : eb[pos - 1];
         for (int c = 0; c < CPB; c++) begin
            if (tx !== ebit) bad++;
            if (!(j == 10 * NB - 1 && c == CPB - 1)) idle(1);
         end
         check($sformatf("bit%0d_cycles_wrong", j), bad, 0);
      end
      check("last_stop_busy", busy, 1);
      idle(1);
      check("after_frame_busy", busy, 0);
      check("after_frame_tx", tx, 1);
      wait_idle(2000);
      check_stream("single", 1'b0);

      // burst of 20 into an idle block: one pop lands inside the burst
      burst(20);
      check("burst_level", fifo_level, DEPTH);
      check("burst_overflow", overflow, 1);
      check("burst_drops", drop_count, 3);
      wait_idle(20000);
      check_stream("burst", 1'b1);
      drive_cycle(1'b0, 10'd0, 1'b1);
      check("clr_overflow", overflow, 0);
      check("clr_drops", drop_count, 0);

      // reset in the middle of byte0 data bits with more samples queued
      burst(3);
      idle(4 * CPB + 1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      check("midrst_tx", tx, 1);
      check("midrst_level", fifo_level, 0);
      check("midrst_busy", busy, 0);
      exp_q.delete();
      exp_seq = 0;
      begin
         int lows;
         lows = 0;
         for (int i = 0; i < 2 * (10 * NB * CPB + 2); i++) begin
            if (tx !== 1'b1) lows++;
            idle(1);
         end
         check("midrst_quiet_cycles", lows, 0);
      end
      check("midrst_rx_bytes", rx_q.size(), 0);
      rx_q.delete();
      start_q.delete();

      // 300 drops saturate; then clear coinciding with a drop, then plain clear
      burst(317);
      check("sat_drops", drop_count, 255);
      check("sat_overflow", overflow, 1);
      drive_cycle(1'b1, 10'($urandom_range(0, 1023)), 1'b1);
      check("clr_drop_overflow", overflow, 1);
      check("clr_drop_count", drop_count, 1);
      drive_cycle(1'b0, 10'd0, 1'b1);
      check("clr2_overflow", overflow, 0);
      check("clr2_count", drop_count, 0);
      wait_idle(20000);
      check_stream("sat", 1'b1);

      // random samples with random spacing
      for (int k = 0; k < 6; k++) begin
         logic [9:0] s;
         s = 10'($urandom);
         drive_cycle(1'b1, s, 1'b0);
         add_expected(s);
         idle($urandom_range(0, 700));
      end
      wait_idle(20000);
      check_stream("rand", 1'b0);
      check("rand_drops", drop_count, 0);

`ifdef ADC_TX_SEQNUM_EN
      // sequence wraps past 127; dropped samples never consume a number
      burst(20);
      wait_idle(20000);
      check_stream("seq_drop", 1'b1);
      drive_cycle(1'b0, 10'd0, 1'b1);
      while (exp_seq < 130) begin
         burst((130 - exp_seq < 13) ? 130 - exp_seq : 13);
         wait_idle(20000);
         check_stream("seq", 1'b1);
      end
`endif

      check("framing_errors", frame_err, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
